mmc_dat_crc_status: RTL and testbench

Write-path stage directly downstream of the DAT serialiser. It is started when the serialiser's block end bit has been driven. It then does three things:
- receives the card's CRC status token on DAT0 (start bit 0, 3-bit status, end bit 1);
- monitors the busy period, in which DAT0 is held low until the card finishes programming;
- reports the outcome as a single completion pulse with result flags.

The write controller uses the result to decide between the next block, a retry, or an error.

---
 rtl/mmc_dat_crc_status.sv | 183 ++++++++++++++++++
 tb/tb_mmc_dat_crc_status.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mmc_dat_crc_status.sv
// mmc_dat_crc_status
//   Write-path stage that follows the DAT serialiser. After the block end bit
//   it looks for the card's CRC status token on DAT0 (start 0, 3 status bits
//   MSB first, end 1). It then waits out the busy period, during which the card
//   holds DAT0 low, and reports the outcome as one completion pulse with
//   result flags.
//
// Parameters
//   STATUS_TIMEOUT : bit samples to wait for the token start bit
//   BUSY_TIMEOUT   : bit samples DAT0 may stay low during busy
//   CNT_W          : width of the shared timeout counter
//
// Ports
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   bitclk_i       : card bit clock level; DAT0 is sampled on its rising edge
//   start_i        : 1-cycle pulse, serialiser finished; begin token search
//   abort_i        : return to idle at once, no completion, flags untouched
//   dat0_i         : raw DAT0 pad input
//   active_o       : operation in progress
//   busy_o         : card busy period being monitored
//   complete_o     : 1-cycle completion pulse
//   status_o       : captured token status bits
//   crc_ok_o, crc_err_o, proto_err_o, timeout_o : result flags, held until
//                    the next accepted start
module mmc_dat_crc_status #(
  parameter int unsigned STATUS_TIMEOUT = 64,
  parameter int unsigned BUSY_TIMEOUT   = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bitclk_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       dat0_i,
  output logic       active_o,
  output logic       busy_o,
  output logic       complete_o,
  output logic [2:0] status_o,
  output logic       crc_ok_o,
  output logic       crc_err_o,
  output logic       proto_err_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_STATUS,
    S_END_BIT,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ST_LIM = CNT_W'(STATUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BT_LIM = CNT_W'(BUSY_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             dat_meta_q, dat_s_q;
  logic             clk_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       bitcnt_q, bitcnt_d;
  logic [2:0]       status_q, status_d;
  logic             ok_q, ok_d, err_q, err_d, pe_q, pe_d, to_q, to_d;
  logic             sample_w;

  assign sample_w = bitclk_i & ~clk_q;
  // Saturating increment: the counter never wraps back under a limit.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_meta_q <= 1'b1;
      dat_s_q    <= 1'b1;
      clk_q      <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      status_q   <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      pe_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      dat_meta_q <= dat0_i;
      dat_s_q    <= dat_meta_q;
      clk_q      <= bitclk_i;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      status_q   <= status_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      pe_q       <= pe_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    status_d = status_q;
    ok_d     = ok_q;
    err_d    = err_q;
    pe_d     = pe_q;
    to_d     = to_q;
    if (abort_i) begin
      // Abort outranks everything; results and status stay as they were.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d  = S_WAIT_START;
            cnt_d    = '0;
            bitcnt_d = '0;
            status_d = '0;
            ok_d     = 1'b0;
            err_d    = 1'b0;
            pe_d     = 1'b0;
            to_d     = 1'b0;
          end
        end
        S_WAIT_START: begin
          if (sample_w) begin
            if (!dat_s_q) begin
              state_d  = S_STATUS;
              bitcnt_d = '0;
            end else if (cnt_q >= ST_LIM) begin
              to_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_STATUS: begin
          if (sample_w) begin
            status_d = {status_q[1:0], dat_s_q};
            bitcnt_d = bitcnt_q + 2'd1;
            if (bitcnt_q == 2'd2) state_d = S_END_BIT;
          end
        end
        S_END_BIT: begin
          if (sample_w) begin
            if (!dat_s_q) pe_d = 1'b1;
            state_d = S_BUSY;
            cnt_d   = '0;
          end
        end
        S_BUSY: begin
          if (sample_w) begin
            if (dat_s_q) begin
              // Token verdict is resolved together with busy release.
              state_d = S_DONE;
              ok_d    = (status_q == 3'b010) & ~pe_q;
              err_d   = (status_q == 3'b101);
              pe_d    = pe_q | ((status_q != 3'b010) & (status_q != 3'b101));
            end else if (cnt_q >= BT_LIM) begin
              to_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign active_o    = (state_q != S_IDLE);
  assign busy_o      = (state_q == S_BUSY);
  assign complete_o  = (state_q == S_DONE);
  assign status_o    = status_q;
  assign crc_ok_o    = ok_q;
  assign crc_err_o   = err_q;
  assign proto_err_o = pe_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_mmc_dat_crc_status.sv
module tb_mmc_dat_crc_status;

  localparam int ST = 64;
  localparam int BT = 100;

  logic       clk, rst, bitclk, start, abort_s, dat0;
  logic       active, busy, complete, crc_ok, crc_err, proto_err, timeout;
  logic [2:0] status;

  mmc_dat_crc_status #(
    .STATUS_TIMEOUT(ST),
    .BUSY_TIMEOUT  (BT),
    .CNT_W         (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bitclk_i   (bitclk),
    .start_i    (start),
    .abort_i    (abort_s),
    .dat0_i     (dat0),
    .active_o   (active),
    .busy_o     (busy),
    .complete_o (complete),
    .status_o   (status),
    .crc_ok_o   (crc_ok),
    .crc_err_o  (crc_err),
    .proto_err_o(proto_err),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cpl_cnt, cpl_at, bits_sent, busy_zero;
  bit busy_seen;
  bit seq[$];

  // Observers sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (complete) begin
      cpl_cnt = cpl_cnt + 1;
      cpl_at  = bits_sent;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bitat(input int k);
    return (k < seq.size()) ? seq[k] : 1'b1;
  endfunction

  // Reference: walk the DAT0 bit list using the token/busy rules directly.
  task automatic model(output int n, output int zeros, output logic [2:0] st,
                       output logic ok, output logic err, output logic pe,
                       output logic to, output logic bz);
    int idx;
    bit found, endbad, rel;
    found = 0; idx = 0; st = 3'b000; ok = 0; err = 0; pe = 0; to = 0;
    zeros = 0; bz = 0; n = 0;
    for (int k = 0; k < ST; k++)
      if (!found && bitat(k) == 1'b0) begin found = 1; idx = k; end
    if (!found) begin n = ST; to = 1; return; end
    st     = {bitat(idx + 1), bitat(idx + 2), bitat(idx + 3)};
    endbad = (bitat(idx + 4) == 1'b0);
    bz     = 1;
    pe     = endbad;
    rel    = 0;
    n      = idx + 5 + BT;
    for (int j = 0; j < BT; j++)
      if (!rel && bitat(idx + 5 + j)) begin rel = 1; n = idx + 5 + j + 1; zeros = j; end
    if (!rel) begin
      to = 1; zeros = BT;
    end else begin
      ok  = (st == 3'b010) && !endbad;
      err = (st == 3'b101);
      pe  = endbad || !((st == 3'b010) || (st == 3'b101));
    end
  endtask

  task automatic push(input bit v, input int cnt);
    for (int i = 0; i < cnt; i++) seq.push_back(v);
  endtask

  task automatic push_tok(input logic [2:0] t);
    for (int i = 2; i >= 0; i--) seq.push_back(t[i]);
  endtask

  // One bit period: data set mid-low phase, then bitclk rises (sample event).
  task automatic send_bit(input bit b);
    @(negedge clk);
    dat0 = b; bitclk = 1'b0;
    repeat (3) @(negedge clk);
    if (busy && !b) busy_zero++;
    bitclk = 1'b1; bits_sent++;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_seq(input string name);
    int n, zeros;
    logic [2:0] st;
    logic ok, err, pe, to, bz;
    model(n, zeros, st, ok, err, pe, to, bz);
    cpl_cnt = 0; cpl_at = -1; bits_sent = 0; busy_zero = 0; busy_seen = 0;
    pulse_start();
    chk({name, "/active_after_start"}, 32'(active), 32'd1);
    foreach (seq[i]) send_bit(seq[i]);
    repeat (4) @(negedge clk);
    chk({name, "/complete_count"}, 32'(cpl_cnt), 32'd1);
    chk({name, "/complete_at_sample"}, 32'(cpl_at), 32'(n));
    chk({name, "/status"}, 32'(status), 32'(st));
    chk({name, "/flags"}, 32'({crc_ok, crc_err, proto_err, timeout}), 32'({ok, err, pe, to}));
    chk({name, "/busy_zero_samples"}, 32'(busy_zero), 32'(zeros));
    chk({name, "/busy_seen"}, 32'(busy_seen), 32'(bz));
    chk({name, "/idle_after"}, 32'(active), 32'd0);
  endtask

  initial begin
    logic [2:0] tok;
    rst = 1'b1; bitclk = 1'b0; start = 1'b0; abort_s = 1'b0; dat0 = 1'b1;
    cpl_cnt = 0; cpl_at = -1; bits_sent = 0; busy_zero = 0; busy_seen = 0;
    #3;
    chk("reset_outputs", 32'({active, busy, complete, status, crc_ok, crc_err, proto_err, timeout}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Good token with 10 busy bits.
    seq.delete(); push(1, 2); push(0, 1); push_tok(3'b010); push(1, 1); push(0, 10); push(1, 3);
    run_seq("token_good");

    // CRC error token, 2 busy bits.
    seq.delete(); push(0, 1); push_tok(3'b101); push(1, 1); push(0, 2); push(1, 3);
    run_seq("crc_error");

    // No start bit ever arrives.
    seq.delete(); push(1, 70);
    run_seq("no_start_bit");

    // Good token, card never releases busy.
    seq.delete(); push(0, 1); push_tok(3'b010); push(1, 1); push(0, 110); push(1, 3);
    run_seq("busy_stuck");

    // Invalid token with bad end bit.
    seq.delete(); push(0, 1); push_tok(3'b011); push(0, 1); push(1, 4);
    run_seq("bad_end_invalid");

    // Zero-length busy.
    seq.delete(); push(0, 1); push_tok(3'b010); push(1, 4);
    run_seq("zero_busy");

    // Randomized transactions.
    for (int r = 0; r < 12; r++) begin
      seq.delete();
      push(1, (r == 5) ? 66 : int'($urandom_range(0, 4)));
      push(0, 1);
      case ($urandom_range(0, 2))
        0:       tok = 3'b010;
        1:       tok = 3'b101;
        default: tok = 3'($urandom_range(0, 7));
      endcase
      push_tok(tok);
      push(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1);
      push(0, int'($urandom_range(0, 12)));
      push(1, 3);
      run_seq($sformatf("random%0d", r));
    end

    // Abort mid-busy; a start pulse while active must be ignored.
    cpl_cnt = 0; bits_sent = 0; busy_zero = 0;
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b0);
    pulse_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    chk("abort/busy_before", 32'(busy), 32'd1);
    @(negedge clk); abort_s = 1'b1;
    @(negedge clk); abort_s = 1'b0;
    chk("abort/active_after", 32'(active), 32'd0);
    chk("abort/busy_after", 32'(busy), 32'd0);
    send_bit(1'b1); send_bit(1'b1);
    chk("abort/no_complete", 32'(cpl_cnt), 32'd0);
    chk("abort/status_kept", 32'(status), 32'(3'b010));
    chk("abort/flags_kept", 32'({crc_ok, crc_err, proto_err, timeout}), 32'd0);

    // Asynchronous reset while receiving the status bits.
    pulse_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("rst_mid/active_before", 32'(active), 32'd1);
    chk("rst_mid/status_before", 32'(status), 32'd1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid/outputs_zero", 32'({active, busy, complete, status, crc_ok, crc_err, proto_err, timeout}), 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid/idle_after", 32'(active), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
